// File: rtl/control_fsm_pkg.sv
// Shared definitions for the multicycle control FSM: opcodes, ALU-control
// requests, mux select encodings, state enumeration and the per-state control word.
// Latency: n/a (package). Backpressure: n/a (package).
// Optional feature macro: JUMP_CTRL_EN adds the JUMP state (op 000010).
package control_fsm_pkg;

  // Opcode field values (instr[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  // ALU-control requests; must match the ALU-control decoder
  localparam logic [2:0] ALUOP_ADD   = 3'b000;
  localparam logic [2:0] ALUOP_SUB   = 3'b001;
  localparam logic [2:0] ALUOP_RTYPE = 3'b010;
  localparam logic [2:0] ALUOP_ADDI  = 3'b011;
  localparam logic [2:0] ALUOP_ORI   = 3'b111;
  localparam logic [2:0] ALUOP_ANDI  = 3'b101;
  localparam logic [2:0] ALUOP_SLTI  = 3'b100;

  // ALU B operand select
  localparam logic [1:0] SRCB_REG   = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  // PC source select
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTEXEC  = 4'd6,
    S_RTWB    = 4'd7,
    S_BRANCH  = 4'd8,
    S_IMMEXEC = 4'd9,
    S_IMMWB   = 4'd10
`ifdef JUMP_CTRL_EN
    , S_JUMP  = 4'd11
`endif
  } state_t;

  typedef struct packed {
    logic       pcwrite;
    logic       pcwritecond;
    logic       iord;
    logic       memread;
    logic       memwrite;
    logic       irwrite;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [2:0] aluop;
  } ctrl_t;

  // ALU request for the immediate-class instructions
  function automatic logic [2:0] imm_aluop(input logic [5:0] op);
    logic [2:0] a;
    a = ALUOP_ADD;
    case (op)
      OP_ADDI: a = ALUOP_ADDI;
      OP_ANDI: a = ALUOP_ANDI;
      OP_ORI:  a = ALUOP_ORI;
      OP_SLTI: a = ALUOP_SLTI;
      default: a = ALUOP_ADD;
    endcase
    return a;
  endfunction

  // Control word for a state; anything not listed stays 0.
  // op only matters in IMMEXEC, where it is already held stable by the IR.
  function automatic ctrl_t state_ctrl(input state_t s, input logic [5:0] op);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.memread = 1'b1;
        c.irwrite = 1'b1;
        c.alusrcb = SRCB_FOUR;
        c.aluop   = ALUOP_ADD;
        c.pcwrite = 1'b1;
        c.pcsrc   = PCSRC_ALU;
      end
      S_DECODE: begin
        // Precompute branch target into ALUOut
        c.alusrcb = SRCB_IMMSH;
        c.aluop   = ALUOP_ADD;
      end
      S_MEMADR: begin
        c.alusrca = 1'b1;
        c.alusrcb = SRCB_IMM;
        c.aluop   = ALUOP_ADD;
      end
      S_MEMRD: begin
        c.memread = 1'b1;
        c.iord    = 1'b1;
      end
      S_MEMWB: begin
        c.regwrite = 1'b1;
        c.memtoreg = 1'b1;
      end
      S_MEMWR: begin
        c.memwrite = 1'b1;
        c.iord     = 1'b1;
      end
      S_RTEXEC: begin
        c.alusrca = 1'b1;
        c.alusrcb = SRCB_REG;
        c.aluop   = ALUOP_RTYPE;
      end
      S_RTWB: begin
        c.regwrite = 1'b1;
        c.regdst   = 1'b1;
      end
      S_BRANCH: begin
        c.alusrca     = 1'b1;
        c.alusrcb     = SRCB_REG;
        c.aluop       = ALUOP_SUB;
        c.pcwritecond = 1'b1;
        c.pcsrc       = PCSRC_ALUOUT;
      end
      S_IMMEXEC: begin
        c.alusrca = 1'b1;
        c.alusrcb = SRCB_IMM;
        c.aluop   = imm_aluop(op);
      end
      S_IMMWB: begin
        c.regwrite = 1'b1;
      end
`ifdef JUMP_CTRL_EN
      S_JUMP: begin
        c.pcwrite = 1'b1;
        c.pcsrc   = PCSRC_JUMP;
      end
`endif
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/control_fsm.sv
// Multicycle datapath main control FSM (FETCH/DECODE/execute/writeback).
// Latency: one state per clock; outputs are registered and valid with the state.
// Backpressure: none; advances every cycle, async rst_n forces FETCH.
// Ports: clk, rst_n, op[5:0] in; PC/memory/IR/regfile/ALU control strobes
// and selects out, plus state[STATE_W-1:0] for debug.
// Optional feature macro: JUMP_CTRL_EN enables the JUMP state for op 000010.
module control_fsm
  import control_fsm_pkg::*;
#(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [5:0]         op,
  output logic               pcwrite,
  output logic               pcwritecond,
  output logic               iord,
  output logic               memread,
  output logic               memwrite,
  output logic               irwrite,
  output logic               regdst,
  output logic               memtoreg,
  output logic               regwrite,
  output logic               alusrca,
  output logic [1:0]         alusrcb,
  output logic [1:0]         pcsrc,
  output logic [2:0]         aluop,
  output logic [STATE_W-1:0] state
);

  state_t cur;
  state_t nxt;
  ctrl_t  ctrl_q;

  always_comb begin
    nxt = S_FETCH;
    case (cur)
      S_FETCH:  nxt = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW:                       nxt = S_MEMADR;
          OP_RTYPE:                           nxt = S_RTEXEC;
          OP_BEQ:                             nxt = S_BRANCH;
          OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI:  nxt = S_IMMEXEC;
`ifdef JUMP_CTRL_EN
          OP_J:                               nxt = S_JUMP;
`endif
          // Unrecognised: drop straight back to a fresh fetch, no writes
          default:                            nxt = S_FETCH;
        endcase
      end
      S_MEMADR:  nxt = (op == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:   nxt = S_MEMWB;
      S_RTEXEC:  nxt = S_RTWB;
      S_IMMEXEC: nxt = S_IMMWB;
      default:   nxt = S_FETCH;
    endcase
  end

  // Control word is registered from the next state, so it always matches
  // the state register (Moore) without a combinational decode on the outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur    <= S_FETCH;
      ctrl_q <= state_ctrl(S_FETCH, 6'b000000);
    end else begin
      cur    <= nxt;
      ctrl_q <= state_ctrl(nxt, op);
    end
  end

  assign pcwrite     = ctrl_q.pcwrite;
  assign pcwritecond = ctrl_q.pcwritecond;
  assign iord        = ctrl_q.iord;
  assign memread     = ctrl_q.memread;
  assign memwrite    = ctrl_q.memwrite;
  assign irwrite     = ctrl_q.irwrite;
  assign regdst      = ctrl_q.regdst;
  assign memtoreg    = ctrl_q.memtoreg;
  assign regwrite    = ctrl_q.regwrite;
  assign alusrca     = ctrl_q.alusrca;
  assign alusrcb     = ctrl_q.alusrcb;
  assign pcsrc       = ctrl_q.pcsrc;
  assign aluop       = ctrl_q.aluop;
  assign state       = STATE_W'(cur);

endmodule

// File: tb/tb_control_fsm.sv
module tb_control_fsm;
  import control_fsm_pkg::*;

  localparam int SW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [5:0]    op = 6'b000000;
  logic          pcwrite, pcwritecond, iord, memread, memwrite, irwrite;
  logic          regdst, memtoreg, regwrite, alusrca;
  logic [1:0]    alusrcb, pcsrc;
  logic [2:0]    aluop;
  logic [SW-1:0] state;

  int errors = 0;
  int checks = 0;

  // Expected control word, field order matching obs below
  typedef struct packed {
    logic       pcwrite, pcwritecond, iord, memread, memwrite, irwrite;
    logic       regdst, memtoreg, regwrite, alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [2:0] aluop;
  } exp_t;

  exp_t obs;
  assign obs = '{pcwrite, pcwritecond, iord, memread, memwrite, irwrite,
                 regdst, memtoreg, regwrite, alusrca, alusrcb, pcsrc, aluop};

  control_fsm #(.STATE_W(SW)) dut (
    .clk(clk), .rst_n(rst_n), .op(op),
    .pcwrite(pcwrite), .pcwritecond(pcwritecond), .iord(iord),
    .memread(memread), .memwrite(memwrite), .irwrite(irwrite),
    .regdst(regdst), .memtoreg(memtoreg), .regwrite(regwrite),
    .alusrca(alusrca), .alusrcb(alusrcb), .pcsrc(pcsrc), .aluop(aluop),
    .state(state)
  );

  always #5 clk = ~clk;

  // Reference: the instruction's walk through the states, from its class.
  state_t seq[$];

  task automatic build_seq(input logic [5:0] o);
    seq = {};
    seq.push_back(S_FETCH);
    seq.push_back(S_DECODE);
    case (o)
      6'b100011: begin seq.push_back(S_MEMADR); seq.push_back(S_MEMRD); seq.push_back(S_MEMWB); end
      6'b101011: begin seq.push_back(S_MEMADR); seq.push_back(S_MEMWR); end
      6'b000000: begin seq.push_back(S_RTEXEC); seq.push_back(S_RTWB); end
      6'b001000, 6'b001100, 6'b001101, 6'b001010: begin
        seq.push_back(S_IMMEXEC); seq.push_back(S_IMMWB);
      end
      6'b000100: seq.push_back(S_BRANCH);
`ifdef JUMP_CTRL_EN
      6'b000010: seq.push_back(S_JUMP);
`endif
      default: ;
    endcase
  endtask

  // Reference: what each step of an instruction must drive.
  function automatic exp_t model_ctrl(input state_t s, input logic [5:0] o);
    exp_t e;
    e = '0;
    if (s == S_FETCH) begin
      e.memread = 1; e.irwrite = 1; e.alusrcb = 2'b01; e.pcwrite = 1;
    end else if (s == S_DECODE) begin
      e.alusrcb = 2'b11;
    end else if (s == S_MEMADR) begin
      e.alusrca = 1; e.alusrcb = 2'b10;
    end else if (s == S_MEMRD) begin
      e.memread = 1; e.iord = 1;
    end else if (s == S_MEMWB) begin
      e.regwrite = 1; e.memtoreg = 1;
    end else if (s == S_MEMWR) begin
      e.memwrite = 1; e.iord = 1;
    end else if (s == S_RTEXEC) begin
      e.alusrca = 1; e.aluop = 3'b010;
    end else if (s == S_RTWB) begin
      e.regwrite = 1; e.regdst = 1;
    end else if (s == S_BRANCH) begin
      e.alusrca = 1; e.aluop = 3'b001; e.pcwritecond = 1; e.pcsrc = 2'b01;
    end else if (s == S_IMMEXEC) begin
      e.alusrca = 1; e.alusrcb = 2'b10;
      e.aluop = (o == 6'b001000) ? 3'b011 :
                (o == 6'b001100) ? 3'b101 :
                (o == 6'b001101) ? 3'b111 : 3'b100;
    end else if (s == S_IMMWB) begin
      e.regwrite = 1;
    end
`ifdef JUMP_CTRL_EN
    else if (s == S_JUMP) begin
      e.pcwrite = 1; e.pcsrc = 2'b10;
    end
`endif
    return e;
  endfunction

  task automatic test_reset;
    exp_t e;
    rst_n = 1'b0;
    e = model_ctrl(S_FETCH, 6'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (state !== SW'(S_FETCH) || obs !== e) begin
        errors++;
        $display("FAIL reset cyc=%0d state got=%0d want=%0d ctrl got=%h want=%h",
                 i, state, S_FETCH, obs, e);
      end
    end
    rst_n = 1'b1; // released at a negedge; next posedge leaves FETCH
  endtask

  // Directed: every opcode class, plus unrecognised codes, back to back.
  task automatic test_opcodes;
    logic [5:0] ops [12];
    exp_t e;
    ops = '{6'b100011, 6'b101011, 6'b000000, 6'b001000, 6'b001100, 6'b001101,
            6'b001010, 6'b000100, 6'b000010, 6'b111111, 6'b000001, 6'b100011};
    for (int i = 0; i < 12; i++) begin
      op = ops[i];
      build_seq(op);
      for (int k = 0; k < seq.size(); k++) begin
        e = model_ctrl(seq[k], op);
        checks++;
        if (state !== SW'(seq[k]) || obs !== e) begin
          errors++;
          $display("FAIL opcode op=%b step=%0d state got=%0d want=%0d ctrl got=%h want=%h",
                   op, k, state, seq[k], obs, e);
        end
        @(negedge clk);
      end
      checks++;
      if (state !== SW'(S_FETCH)) begin
        errors++;
        $display("FAIL opcode_len op=%b state got=%0d want=%0d after %0d cycles",
                 op, state, S_FETCH, seq.size());
      end
    end
  endtask

  // Random opcodes: half drawn from the legal set, half anything.
  task automatic test_random;
    logic [5:0] legal [10];
    exp_t e;
    legal = '{6'b100011, 6'b101011, 6'b000000, 6'b001000, 6'b001100,
              6'b001101, 6'b001010, 6'b000100, 6'b000010, 6'b000000};
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 1) == 0) op = legal[$urandom_range(0, 9)];
      else op = 6'($urandom);
      build_seq(op);
      for (int k = 0; k < seq.size(); k++) begin
        e = model_ctrl(seq[k], op);
        checks++;
        if (state !== SW'(seq[k]) || obs !== e) begin
          errors++;
          $display("FAIL random op=%b step=%0d state got=%0d want=%0d ctrl got=%h want=%h",
                   op, k, state, seq[k], obs, e);
        end
`ifndef JUMP_CTRL_EN
        checks++;
        if (pcsrc === 2'b10) begin
          errors++;
          $display("FAIL nojump_pcsrc op=%b step=%0d pcsrc got=%b want!=10", op, k, pcsrc);
        end
`endif
        @(negedge clk);
      end
      checks++;
      if (state !== SW'(S_FETCH)) begin
        errors++;
        $display("FAIL random_len op=%b state got=%0d want=%0d", op, state, S_FETCH);
      end
    end
  endtask

  // Reset pulse between edges while in MEMRD must take effect immediately.
  task automatic test_async_reset;
    exp_t e;
    op = 6'b100011;
    repeat (3) @(negedge clk);
    checks++;
    if (state !== SW'(S_MEMRD)) begin
      errors++;
      $display("FAIL async_pre state got=%0d want=%0d", state, S_MEMRD);
    end
    #2 rst_n = 1'b0;
    #1;
    e = model_ctrl(S_FETCH, op);
    checks++;
    if (state !== SW'(S_FETCH) || memread !== 1'b1 || iord !== 1'b0 || obs !== e) begin
      errors++;
      $display("FAIL async_rst state got=%0d want=%0d memread=%b iord=%b ctrl got=%h want=%h",
               state, S_FETCH, memread, iord, obs, e);
    end
    #1 rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (state !== SW'(S_DECODE)) begin
      errors++;
      $display("FAIL async_release state got=%0d want=%0d", state, S_DECODE);
    end
    op = 6'b111111;
    @(negedge clk);
    checks++;
    if (state !== SW'(S_FETCH) || obs !== e) begin
      errors++;
      $display("FAIL async_unknown state got=%0d want=%0d ctrl got=%h want=%h",
               state, S_FETCH, obs, e);
    end
  endtask

  initial begin
    test_reset;
    test_opcodes;
    test_random;
    test_async_reset;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/control_fsm.md
CONTROL_FSM -- requirements
Module: control_fsm

Interface
REQ-001 Parameter: STATE_W, default 4, width of the state register (SHALL be >= 4).
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 op  input  6  opcode field of the instruction register (instr[31:26]).
REQ-005 pcwrite, pcwritecond  output  1 each  unconditional and branch-conditional PC write enables.
REQ-006 iord, memread, memwrite, irwrite  output  1 each  memory address select (0=PC, 1=ALUOut), read and write strobes, IR load.
REQ-007 regdst, memtoreg, regwrite, alusrca  output  1 each  dest select (1=rd), writeback select (1=MDR), register-file write, ALU A select (1=reg A).
REQ-008 alusrcb  output  2  ALU B select: 00=reg B, 01=constant 4, 10=sign-ext imm, 11=sign-ext imm<<2.
REQ-009 pcsrc  output  2  PC source: 00=ALU result, 01=ALUOut, 10=jump target.
REQ-010 aluop  output  3  ALU-control request: 000 add, 001 sub, 010 R-type by funct, 011 addi, 111 ori, 101 andi, 100 slti.
REQ-011 state  output  STATE_W  current state code for debug and bench.

Function
REQ-012 States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTEXEC, RTWB, BRANCH, IMMEXEC, IMMWB, plus JUMP when configured.
REQ-013 Every output not asserted by the current state SHALL be 0; outputs are a pure Moore function of state.
REQ-014 FETCH: memread=1, irwrite=1, alusrcb=01, aluop=000, pcwrite=1, pcsrc=00; next DECODE.
REQ-015 DECODE: alusrcb=11, aluop=000 (branch target into ALUOut); next by op: 100011/101011 -> MEMADR, 000000 -> RTEXEC, 000100 -> BRANCH, 001000/001100/001101/001010 -> IMMEXEC, 000010 -> JUMP (if enabled).
REQ-016 Unrecognised op in DECODE SHALL go to FETCH with no register/memory write (3rd cycle is a fresh fetch).
REQ-017 MEMADR: alusrca=1, alusrcb=10, aluop=000; next MEMRD if op=100011, MEMWR if op=101011.
REQ-018 MEMRD: memread=1, iord=1 -> MEMWB. MEMWB: regwrite=1, memtoreg=1, regdst=0 -> FETCH. MEMWR: memwrite=1, iord=1 -> FETCH.
REQ-019 RTEXEC: alusrca=1, alusrcb=00, aluop=010 -> RTWB. RTWB: regwrite=1, regdst=1, memtoreg=0 -> FETCH.
REQ-020 BRANCH: alusrca=1, alusrcb=00, aluop=001, pcwritecond=1, pcsrc=01 -> FETCH.
REQ-021 IMMEXEC: alusrca=1, alusrcb=10, aluop by op: 001000->011, 001100->101, 001101->111, 001010->100 -> IMMWB. IMMWB: regwrite=1, regdst=0, memtoreg=0 -> FETCH.
REQ-022 Cycle counts per instruction: lw 5, sw 4, R-type 4, immediate 4, beq 3, j 3, unknown 2.
REQ-023 op SHALL be sampled every cycle; it is stable from DECODE onward because irwrite is asserted only in FETCH.

Reset
REQ-024 rst_n low SHALL force state=FETCH immediately (asynchronously), including mid-instruction; all outputs then take FETCH values.
REQ-025 The first rising clk edge after rst_n deasserts SHALL advance FETCH -> DECODE.

Configuration
REQ-026 Macro JUMP_CTRL_EN: defined -> JUMP state present, op 000010 in DECODE -> JUMP; JUMP asserts pcwrite=1, pcsrc=10 -> FETCH.
REQ-027 JUMP_CTRL_EN undefined -> no JUMP state; 000010 is treated as unrecognised per REQ-016; pcsrc never equals 10.

Structure
REQ-028 Shared package: opcode constants, aluop encodings (matching the ALU-control decoder), alusrcb/pcsrc encodings, state enumeration.
REQ-029 Single module: state register plus next-state and output logic; no sub-module.

Verification
REQ-030 Reset held low 3 cycles, release, op=100011 -> states FETCH,DECODE,MEMADR,MEMRD,MEMWB,FETCH; regwrite=1 and memtoreg=1 only in MEMWB.
REQ-031 op=000000 -> RTEXEC aluop=010, RTWB regwrite=1 regdst=1; back in FETCH after 4 cycles.
REQ-032 op=001101 -> IMMEXEC aluop=111 alusrcb=10; op=001010 -> aluop=100; op=001100 -> aluop=101.
REQ-033 op=000100 -> BRANCH with aluop=001, pcwritecond=1, pcsrc=01, pcwrite=0; FETCH next cycle.
REQ-034 op=000010: with JUMP_CTRL_EN -> JUMP pcwrite=1 pcsrc=10; without -> DECODE then FETCH, no write strobes.
REQ-035 rst_n pulsed low between clock edges during MEMRD -> state=FETCH before next edge; memread/iord reflect FETCH values.
